// File: rtl/atm_ledger_arbiter.sv
// atm_ledger_arbiter
//   Shared account ledger for several ATM front-ends. A round-robin arbiter
//   grants one requester at a time. The granted transaction (inquiry,
//   withdraw, deposit or transfer) is applied to the internal balance
//   register file as a single atomic read-modify-write.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset (ledger and all state)
//   req        : per-requester request, payload stable while high
//   req_op     : 3-bit opcode per requester (001 inq, 010 wd, 011 dep, 100 xfer)
//   req_src    : source/own account index per requester
//   req_dst    : destination account index per requester (transfer only)
//   req_amount : amount per requester
//   grant      : registered one-hot grant
//   done       : one-cycle completion pulse
//   status     : 00 ok, 01 insufficient, 10 invalid, 11 overflow (held)
//   balance    : source balance after the operation (held)
//   busy       : arbiter is not idle
module atm_ledger_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int IDX_W        = 3,
  parameter int AMT_W        = 19,
  parameter int INIT_BALANCE = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [IDX_W*NUM_REQ-1:0] req_src,
  input  logic [IDX_W*NUM_REQ-1:0] req_dst,
  input  logic [AMT_W*NUM_REQ-1:0] req_amount,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     done,
  output logic [1:0]               status,
  output logic [AMT_W-1:0]         balance,
  output logic                     busy
);

  localparam int NUM_ACCTS = 1 << IDX_W;
  localparam int PTR_W     = $clog2(NUM_REQ);

  localparam logic [2:0] OP_INQ = 3'b001;
  localparam logic [2:0] OP_WD  = 3'b010;
  localparam logic [2:0] OP_DEP = 3'b011;
  localparam logic [2:0] OP_XFR = 3'b100;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_NSF   = 2'b01;
  localparam logic [1:0] ST_INVAL = 2'b10;
  localparam logic [1:0] ST_OVF   = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  // Per-requester payload views
  logic [2:0]       op_arr  [NUM_REQ];
  logic [IDX_W-1:0] src_arr [NUM_REQ];
  logic [IDX_W-1:0] dst_arr [NUM_REQ];
  logic [AMT_W-1:0] amt_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_arr[gi]  = req_op[3*gi +: 3];
    assign src_arr[gi] = req_src[IDX_W*gi +: IDX_W];
    assign dst_arr[gi] = req_dst[IDX_W*gi +: IDX_W];
    assign amt_arr[gi] = req_amount[AMT_W*gi +: AMT_W];
  end

  state_e             state_q;
  logic [PTR_W-1:0]   rr_q;
  logic [PTR_W-1:0]   win_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               done_q;
  logic [1:0]         status_q;
  logic [AMT_W-1:0]   balance_q;
  logic [2:0]         op_q;
  logic [IDX_W-1:0]   src_q;
  logic [IDX_W-1:0]   dst_q;
  logic [AMT_W-1:0]   amt_q;
  logic [AMT_W-1:0]   ledger_q [NUM_ACCTS];

  // Round-robin winner: first asserted req at or above rr_q, wrapping.
  // rr_q + i < 2*NUM_REQ, so a single conditional subtract wraps it.
  logic [PTR_W-1:0] win_idx;
  logic             win_found;
  logic [PTR_W:0]   cand;

  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ))
        cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!win_found && req[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Transaction evaluation on the latched payload
  logic [AMT_W-1:0] src_bal;
  logic [AMT_W-1:0] dst_bal;
  logic [AMT_W:0]   src_sum;
  logic [AMT_W:0]   dst_sum;
  logic [1:0]       status_d;
  logic [AMT_W-1:0] src_new_d;
  logic [AMT_W-1:0] dst_new_d;
  logic             wr_src;
  logic             wr_dst;

  assign src_bal = ledger_q[src_q];
  assign dst_bal = ledger_q[dst_q];
  assign src_sum = {1'b0, src_bal} + {1'b0, amt_q};
  assign dst_sum = {1'b0, dst_bal} + {1'b0, amt_q};

  always_comb begin
    status_d  = ST_OK;
    src_new_d = src_bal;
    dst_new_d = dst_bal;
    wr_src    = 1'b0;
    wr_dst    = 1'b0;
    case (op_q)
      OP_INQ: status_d = ST_OK;
      OP_WD: begin
        if (amt_q > src_bal) begin
          status_d = ST_NSF;
        end else begin
          wr_src    = 1'b1;
          src_new_d = src_bal - amt_q;
        end
      end
      OP_DEP: begin
        if (src_sum[AMT_W]) begin
          status_d = ST_OVF;
        end else begin
          wr_src    = 1'b1;
          src_new_d = src_sum[AMT_W-1:0];
        end
      end
      OP_XFR: begin
        // Check order matters: self-transfer, then funds, then dst overflow.
        if (src_q == dst_q) begin
          status_d = ST_INVAL;
        end else if (amt_q > src_bal) begin
          status_d = ST_NSF;
        end else if (dst_sum[AMT_W]) begin
          status_d = ST_OVF;
        end else begin
          wr_src    = 1'b1;
          wr_dst    = 1'b1;
          src_new_d = src_bal - amt_q;
          dst_new_d = dst_sum[AMT_W-1:0];
        end
      end
      default: status_d = ST_INVAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      win_q     <= '0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      status_q  <= ST_OK;
      balance_q <= '0;
      op_q      <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      amt_q     <= '0;
      for (int a = 0; a < NUM_ACCTS; a++)
        ledger_q[a] <= AMT_W'(INIT_BALANCE);
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            op_q    <= op_arr[win_idx];
            src_q   <= src_arr[win_idx];
            dst_q   <= dst_arr[win_idx];
            amt_q   <= amt_arr[win_idx];
            win_q   <= win_idx;
            grant_q <= NUM_REQ'(1) << win_idx;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // Ledger write, status and done all land on this one edge.
          if (wr_src) ledger_q[src_q] <= src_new_d;
          if (wr_dst) ledger_q[dst_q] <= dst_new_d;
          status_q  <= status_d;
          balance_q <= src_new_d;
          done_q    <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          grant_q <= '0;
          if (win_q == PTR_W'(NUM_REQ-1))
            rr_q <= '0;
          else
            rr_q <= win_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign status  = status_q;
  assign balance = balance_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Testbench for atm_ledger_arbiter: directed scenarios followed by
// randomized multi-requester rounds, checked against a behavioural ledger
// model (integer balances, round-robin pick over a request mask).
module tb_atm_ledger_arbiter;

  localparam int N    = 4;
  localparam int IW   = 3;
  localparam int AW   = 19;
  localparam int NACC = 8;
  localparam int INIT = 1000;
  localparam int MAXB = (1 << AW) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req;
  logic [3*N-1:0]    req_op;
  logic [IW*N-1:0]   req_src;
  logic [IW*N-1:0]   req_dst;
  logic [AW*N-1:0]   req_amount;
  logic [N-1:0]      grant;
  logic              done;
  logic [1:0]        status;
  logic [AW-1:0]     balance;
  logic              busy;

  logic [2:0]        t_op  [N];
  logic [IW-1:0]     t_src [N];
  logic [IW-1:0]     t_dst [N];
  logic [AW-1:0]     t_amt [N];

  int vectors     = 0;
  int miscompares = 0;
  int m_led [NACC];
  int m_rr;

  atm_ledger_arbiter #(
    .NUM_REQ(N), .IDX_W(IW), .AMT_W(AW), .INIT_BALANCE(INIT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op),
    .req_src(req_src), .req_dst(req_dst), .req_amount(req_amount),
    .grant(grant), .done(done), .status(status), .balance(balance),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_op     = '0;
    req_src    = '0;
    req_dst    = '0;
    req_amount = '0;
    for (int k = 0; k < N; k++) begin
      req_op[3*k +: 3]       = t_op[k];
      req_src[IW*k +: IW]    = t_src[k];
      req_dst[IW*k +: IW]    = t_dst[k];
      req_amount[AW*k +: AW] = t_amt[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < NACC; a++) m_led[a] = INIT;
    m_rr = 0;
  endtask

  function automatic int pick(input int rr, input logic [N-1:0] m);
    for (int i = 0; i < N; i++)
      if (m[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction

  // Applies requester w's payload to the model ledger.
  task automatic model_apply(input int w, output int st, output int bal);
    int s, d, amt;
    s   = int'(t_src[w]);
    d   = int'(t_dst[w]);
    amt = int'(t_amt[w]);
    st  = 0;
    case (t_op[w])
      3'd1: st = 0;
      3'd2: if (amt > m_led[s]) st = 1; else m_led[s] -= amt;
      3'd3: if (m_led[s] + amt > MAXB) st = 3; else m_led[s] += amt;
      3'd4: begin
        if (s == d) st = 2;
        else if (amt > m_led[s]) st = 1;
        else if (m_led[d] + amt > MAXB) st = 3;
        else begin
          m_led[s] -= amt;
          m_led[d] += amt;
        end
      end
      default: st = 2;
    endcase
    bal = m_led[s];
  endtask

  task automatic post(input int k, input int op, input int s, input int d, input int amt);
    t_op[k]  = 3'(op);
    t_src[k] = IW'(s);
    t_dst[k] = IW'(d);
    t_amt[k] = AW'(amt);
    req[k]   = 1'b1;
  endtask

  // Call at a negedge with the DUT idle; serves every pending request.
  task automatic serve_all();
    int w, st, bal;
    while (req != '0) begin
      w = pick(m_rr, req);
      @(posedge clk); @(negedge clk);
      check("grant", 32'(grant), 32'(1) << w);
      check("busy", 32'(busy), 1);
      check("done_early", 32'(done), 0);
      model_apply(w, st, bal);
      @(posedge clk); @(negedge clk);
      check("done", 32'(done), 1);
      check("status", 32'(status), st);
      check("balance", 32'(balance), bal);
      check("grant_hold", 32'(grant), 32'(1) << w);
      req[w] = 1'b0;
      m_rr   = (w + 1) % N;
      @(posedge clk); @(negedge clk);
      check("grant_clr", 32'(grant), 0);
      check("done_clr", 32'(done), 0);
      check("idle", 32'(busy), 0);
      $display("txn req%0d op%0d src%0d dst%0d amt%0d -> st%0d bal%0d",
               w, t_op[w], t_src[w], t_dst[w], t_amt[w], status, balance);
    end
  endtask

  initial begin
    int r, op, amt;
    logic [N-1:0] mask;
    req = '0;
    for (int k = 0; k < N; k++) begin
      t_op[k] = '0; t_src[k] = '0; t_dst[k] = '0; t_amt[k] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_status", 32'(status), 0);
    check("rst_balance", 32'(balance), 0);
    check("rst_busy", 32'(busy), 0);

    // Directed ledger scenarios
    post(0, 1, 5, 0, 0);       serve_all(); check("inq5", 32'(balance), 1000);
    post(0, 2, 0, 0, 500);     serve_all(); check("wd500", 32'(balance), 500);
    post(0, 2, 0, 0, 1500);    serve_all(); check("wd1500_st", 32'(status), 1);
    check("wd1500_bal", 32'(balance), 500);
    post(1, 4, 2, 3, 200);     serve_all(); check("xfr_bal", 32'(balance), 800);
    post(1, 1, 3, 0, 0);       serve_all(); check("inq3", 32'(balance), 1200);
    post(1, 4, 3, 3, 50);      serve_all(); check("xfr_self", 32'(status), 2);
    check("xfr_self_bal", 32'(balance), 1200);
    post(2, 3, 4, 0, 524000);  serve_all(); check("dep_ovf", 32'(status), 3);
    check("dep_ovf_bal", 32'(balance), 1000);
    post(2, 7, 4, 0, 10);      serve_all(); check("op111", 32'(status), 2);
    post(3, 2, 6, 0, 0);       serve_all(); check("amt0", 32'(balance), 1000);

    // All four held: expect 0,1,2,3 order after re-centring rr to 0
    post(3, 1, 7, 0, 0);       serve_all();   // rr now 0
    for (int k = 0; k < N; k++) post(k, 1, k, 0, 0);
    serve_all();
    // rr=2 with requesters 0 and 3 pending: 3 wins first
    post(1, 1, 1, 0, 0);       serve_all();   // rr now 2
    post(0, 1, 0, 0, 0);
    post(3, 1, 3, 0, 0);
    @(posedge clk); @(negedge clk);
    check("rr_pref3", 32'(grant), 32'h8);
    @(posedge clk); @(negedge clk);
    req[3] = 1'b0;
    @(posedge clk); @(negedge clk);
    m_rr = 0;
    serve_all();

    // Reset during EXEC of a withdraw of 300 from account 1
    post(0, 2, 1, 0, 300);
    @(posedge clk); @(negedge clk);
    check("rx_grant", 32'(grant), 1);
    #2 reset = 1'b0;
    #1;
    check("rx_grant0", 32'(grant), 0);
    check("rx_busy0", 32'(busy), 0);
    check("rx_done0", 32'(done), 0);
    req = '0;
    @(posedge clk); @(negedge clk);
    check("rx_nodone", 32'(done), 0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("rx_idle", 32'(busy), 0);
    post(2, 1, 1, 0, 0);       serve_all(); check("rx_acct1", 32'(balance), 1000);

    // Randomized rounds
    for (int it = 0; it < 40; it++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        if (mask[k]) begin
          r  = $urandom_range(0, 9);
          op = (r < 8) ? r : ((r == 8) ? 2 : 4);
          case ($urandom_range(0, 3))
            0:       amt = 0;
            1:       amt = $urandom_range(0, 2000);
            2:       amt = $urandom_range(520000, MAXB);
            default: amt = int'($urandom & MAXB);
          endcase
          post(k, op, $urandom_range(0, NACC - 1), $urandom_range(0, NACC - 1), amt);
        end
      end
      serve_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/atm_ledger_arbiter.md
# atm_ledger_arbiter

Shared account-ledger engine for the multi-terminal ATM build. It holds the balances of a small bank of accounts in an internal register file. Up to NUM_REQ ATM front-ends share it through a round-robin request/grant handshake. For each granted transaction it performs one atomic read-modify-write (balance inquiry, withdraw, deposit or transfer) and returns a status code and the resulting balance.

## Interface
- NUM_REQ, 4, number of ATM front-ends (2..8)
- IDX_W, 3, account index width; ledger depth NUM_ACCTS = 2**IDX_W
- AMT_W, 19, amount/balance width, unsigned
- INIT_BALANCE, 1000, balance loaded into every account at reset

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; ledger and all state initialised while low
- req  in  NUM_REQ  per-requester request; payload must be stable while req is high
- req_op  in  3*NUM_REQ  opcode per requester (slice k = [3k+2:3k]); 001 inquiry, 010 withdraw, 011 deposit, 100 transfer
- req_src  in  IDX_W*NUM_REQ  source/own account index per requester
- req_dst  in  IDX_W*NUM_REQ  destination account index (transfer only)
- req_amount  in  AMT_W*NUM_REQ  amount per requester
- grant  out  NUM_REQ  one-hot grant, registered
- done  out  1  one-cycle completion pulse for the granted requester
- status  out  2  00 ok, 01 insufficient funds, 10 invalid, 11 overflow; valid when done=1, held until the next done
- balance  out  AMT_W  source-account balance after the operation; valid with done, held until the next done
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If any req bit is high, select the winner by round-robin, searching upward from pointer rr and wrapping.
  - At the clock edge: latch the winner's op/src/dst/amount, assert grant[winner], go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - At the clock edge: evaluate on the latched payload and write the ledger (see rules below).
  - Register status and balance, pulse done, go to DONE.
  - grant stays high.
- DONE:
  - At the clock edge: clear grant, set rr = winner+1 mod NUM_REQ, go to IDLE.
- Opcode rules (the ledger is written only when status=00):
  - Inquiry: status 00; balance = src balance.
  - Withdraw: if amount > src balance, status 01. Else src -= amount.
  - Deposit: compute src + amount at AMT_W+1 bits. If the carry bit is set, status 11. Else src updated.
  - Transfer: if src == dst, status 10. Else if amount > src balance, status 01. Else if dst + amount carries, status 11. Else src and dst are both updated in the same edge.
  - Any other opcode (000, 101, 110, 111): status 10, no write.
  - Amount 0 is legal: status 00, balances unchanged.
- balance output always reflects the source account after the operation, including the unchanged value on any error.

## Timing
- Reset values:
  - grant 0, done 0, status 00, balance 0, busy 0.
  - State IDLE, rr 0.
  - Every ledger entry = INIT_BALANCE.
- Latency, counting from the edge that samples req high in IDLE:
  - Edge 1: grant high.
  - Edge 2: done, status and balance.
  - Edge 3: grant low.
- The minimum spacing between grants is 3 cycles.
- Requester handshake:
  - Hold req and payload until done.
  - Deassert req in the done cycle.
  - A req still high after DONE is treated as a new request, at lowest priority because rr has advanced past it.
- Dropping req after grant does not abort the transaction; the latched payload completes.
- Simultaneous requests: exactly one grant. Non-winners wait with no side effects.
- Reset asserted in any state:
  - Outputs go to their reset values immediately.
  - The ledger reinitialises.
  - A transaction not yet past its EXEC edge leaves no write.
- The ledger write, done and status all occur on the same EXEC edge. No partial transfer is ever observable.

## Test plan
- Reset check: after reset release, all outputs are 0. Inquiry on account 5 -> done, status 00, balance 1000.
- Requester 0 withdraws 500 from account 0 -> grant[0] at edge 1, done at edge 2, status 00, balance 500. A repeat withdraw of 1500 -> status 01, balance 500.
- Requester 1 transfers 200 from account 2 to account 3 -> status 00, balance 800. Inquiry on account 3 -> 1200. Transfer 3->3 -> status 10, no change.
- Deposit 524000 into account 4 (1000; sum exceeds 2^19-1) -> status 11, balance 1000. Opcode 111 -> status 10.
- All four req high and held continuously -> grants in order 0, 1, 2, 3, 0, each 3 cycles apart, exactly one done per grant. With rr=2 and req={0,3} -> grant 3 first.
- Reset pulsed low during EXEC of a withdraw of 300 from account 1 -> no done. After release, account 1 reads 1000, grant is 0 and the FSM is in IDLE.
